piano_core: RTL and testbench
=============================

# piano_core

Sound-and-light engine of the electronic piano: produces the speaker square wave, the 8 note LEDs and the learning-mode score for the three playing modes. Sits under the top-level mode selector, beside the 7-segment driver; that driver consumes `finished` and `score`. Auto mode plays a stored song. Free mode sounds the pressed key. Learning mode lights the expected note, waits for the player, and scores reaction time.

## Interface
- `CLK_HZ`, default 100_000_000: clock frequency; sets the tone dividers.
- `BEAT_CYCLES`, default 25_000_000: cycles per note slot (0.25 s).
- `clk`  in  1: system clock; the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `mode`  in  3: 011 auto, 001 free, 111 learning; any other value means idle.
- `song_num`  in  2: song select, 0..3.
- `pause`  in  1: freezes auto playback while high.
- `key`  in  7: bits 0..6 are do..si; level, one bit per key, debounced upstream.
- `pitch`  in  2: 01 low, 00 middle, 10 high; 11 is treated as middle.
- `speaker`  out  1: square wave.
- `led`  out  8: note indicator.
- `finished`  out  1: learning song complete.
- `score`  out  33: learning score, unsigned.

## Operation
- **Tone table:** middle octave is 262, 294, 330, 349, 392, 440, 494 Hz for notes 1..7.
  - Low pitch: half-period ×2. High pitch: half-period ÷2.
  - Half-period = CLK_HZ/(2·f), truncated.
  - Speaker toggles at each half-period. With no tone selected, speaker is held 0 and the divider is cleared.
- **Song ROM:** 4 songs, up to 32 slots each.
  - Slot = {pitch[1:0], note[2:0]}. note 0 = rest. {2'b11, 3'b000} = end marker.
  - Song 0 starts C C G G A A G (middle), then rest.
- **Auto (011):**
  - The slot index advances every BEAT_CYCLES.
  - While pause=1: beat counter and index are frozen, speaker is 0, led[7]=1.
  - Otherwise led = one-hot led[note-1] for the current note; led is 0 on a rest.
  - On reaching the end marker, the index wraps to 0 (see Configuration).
- **Free (001):**
  - Tone = lowest-index set bit of `key`, at `pitch`. led = 0.
  - No key pressed: speaker 0.
- **Learning (111):**
  - led lights the expected note (one-hot).
  - Speaker plays the pressed key as in Free mode.
  - Scoring applies on a rising edge of `key` (no bits → some bits):
    - Correct: key == one-hot of the expected note and pitch matches. Adds max(0, 8 − beats_waited) to score and advances the index; beats_waited then clears.
    - Wrong: no advance, no points.
  - Rest slots advance automatically after one beat and score nothing.
  - On the end marker: finished=1, led=0, score frozen.
- **Clear events:** leaving a mode, entering a mode, or changing song_num clears the index, beat counter, beats_waited, finished and score.
- **Idle mode:** speaker 0, led 0, finished 0, score 0.

## Timing
- Reset: speaker=0, led=0, finished=0, score=0, all counters and indices 0.
- All outputs are registered. mode, song_num, key and pitch take effect 1 cycle after they are sampled.
- Key edge detection uses a 1-cycle delayed copy of `key`.
- Reset asserted mid-song returns every state to reset values immediately.
- pause rising or falling takes effect on the next clock; the beat counter resumes from its frozen value.
- Correct press and beat tick in the same cycle: the press is scored with the pre-tick beats_waited.
- score never wraps in practice: at most 32 × 8 points.

## Configuration
- `AUTO_LOOP_EN` defined: auto mode wraps to slot 0 at the end marker and keeps playing.
- `AUTO_LOOP_EN` undefined: auto mode stops at the end marker with speaker 0 and led 0 until song_num or mode changes.

## Structure
- Package `piano_pkg` holds:
  - mode encodings (MODE_AUTO, MODE_FREE, MODE_LEARN);
  - pitch encodings;
  - the note frequency table;
  - the slot typedef and the END_SLOT constant;
  - the song ROM contents.
- Sub-module `tone_gen` (note, pitch → speaker square wave) is shared by all modes.

## Test plan
All scenarios use CLK_HZ=100_000 and BEAT_CYCLES=1000.
- Reset, then mode=001, key=0100000, pitch=00 → speaker period 226 cycles (half-period 113); led=0.
- Same key, pitch=01, then pitch=10 → half-periods 226 and 56.
- mode=011, song 0 → led sequence 0x01, 0x01, 0x10, 0x10, 0x20, 0x20, 0x10, changing every 1000 cycles.
- Auto mode, pause=1 for 3000 cycles → led=0x80, speaker 0; after release, playback resumes at the same slot.
- mode=111, song 0, correct key pressed 1.5 beats after the slot opens → score +7; a wrong key first → no change.
- Learning mode, all keys correct and immediate → finished=1 with score = 8 × (number of non-rest slots). Changing song_num → finished=0, score=0.

Source files
------------

// File: rtl/piano_pkg.sv
// piano_pkg: shared definitions for the piano sound-and-light engine.
//   - mode and pitch encodings
//   - middle-octave note frequency table (Hz, index 1..7 = do..si)
//   - song slot type, end marker, song ROM lookup
//   - small helpers: pitch normalisation, note-to-LED one-hot, lowest pressed key
package piano_pkg;

    localparam logic [2:0] MODE_AUTO  = 3'b011;
    localparam logic [2:0] MODE_FREE  = 3'b001;
    localparam logic [2:0] MODE_LEARN = 3'b111;

    localparam logic [1:0] PITCH_MID     = 2'b00;
    localparam logic [1:0] PITCH_LOW     = 2'b01;
    localparam logic [1:0] PITCH_HIGH    = 2'b10;
    localparam logic [1:0] PITCH_ALT_MID = 2'b11;

    // Index 0 stands for "no note" and is never divided by.
    localparam int unsigned NOTE_HZ [0:7] = '{32'd0, 32'd262, 32'd294, 32'd330,
                                              32'd349, 32'd392, 32'd440, 32'd494};

    typedef struct packed {
        logic [1:0] pitch;
        logic [2:0] note;   // 0 = rest
    } slot_t;

    localparam slot_t END_SLOT = '{pitch: 2'b11, note: 3'b000};

    // Pitch code 11 behaves exactly like middle.
    function automatic logic [1:0] norm_pitch(input logic [1:0] p);
        return (p == PITCH_ALT_MID) ? PITCH_MID : p;
    endfunction

    // One-hot LED for a note; a rest lights nothing.
    function automatic logic [7:0] note_led(input logic [2:0] note);
        logic [7:0] l;
        case (note)
            3'd0:    l = 8'h00;
            default: l = 8'h01 << (note - 3'd1);
        endcase
        return l;
    endfunction

    // Note number (1..7) of the lowest-index pressed key, 0 when none.
    function automatic logic [2:0] lowest_key(input logic [6:0] key);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            n = key[i] ? 3'(i + 1) : n;
        end
        return n;
    endfunction

    // Song ROM: 4 songs, unlisted slots read as the end marker.
    function automatic slot_t song_slot(input logic [1:0] song, input logic [4:0] idx);
        slot_t s;
        s = END_SLOT;
        case (song)
            2'd0: begin
                case (idx)
                    5'd0, 5'd1:       s = 5'b00_001;
                    5'd2, 5'd3, 5'd6: s = 5'b00_101;
                    5'd4, 5'd5:       s = 5'b00_110;
                    5'd7:             s = 5'b00_000;
                    default:          s = END_SLOT;
                endcase
            end
            2'd1: begin
                case (idx)
                    5'd0, 5'd4, 5'd5, 5'd6: s = 5'b00_011;
                    5'd1, 5'd3:             s = 5'b00_010;
                    5'd2:                   s = 5'b00_001;
                    5'd7:                   s = 5'b00_000;
                    default:                s = END_SLOT;
                endcase
            end
            2'd2: begin
                case (idx)
                    5'd0:    s = 5'b01_001;
                    5'd1:    s = 5'b01_101;
                    5'd2:    s = 5'b00_001;
                    5'd3:    s = 5'b10_001;
                    5'd4:    s = 5'b00_000;
                    5'd5:    s = 5'b10_101;
                    default: s = END_SLOT;
                endcase
            end
            default: begin
                case (idx)
                    5'd0:    s = 5'b00_001;
                    5'd1:    s = 5'b00_010;
                    5'd2:    s = 5'b00_011;
                    5'd3:    s = 5'b00_100;
                    5'd4:    s = 5'b00_101;
                    5'd5:    s = 5'b00_110;
                    5'd6:    s = 5'b00_111;
                    5'd7:    s = 5'b10_001;
                    default: s = END_SLOT;
                endcase
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/piano_if.sv
// piano_if: control and indicator bundle between the mode selector / display
// side (master) and piano_core (slave).
//   mode[2:0], song_num[1:0], pause, key[6:0], pitch[1:0] : master -> core
//   speaker, led[7:0], finished, score[32:0]               : core -> master
interface piano_if;
    logic [2:0]  mode;
    logic [1:0]  song_num;
    logic        pause;
    logic [6:0]  key;
    logic [1:0]  pitch;
    logic        speaker;
    logic [7:0]  led;
    logic        finished;
    logic [32:0] score;

    modport master (
        output mode, song_num, pause, key, pitch,
        input  speaker, led, finished, score
    );

    modport slave (
        input  mode, song_num, pause, key, pitch,
        output speaker, led, finished, score
    );
endinterface

// File: rtl/piano_core_tone_gen.sv
// tone_gen: square-wave generator for one note at one of three octaves.
//   clk, rst_n : clock, async active-low reset
//   note_i     : 1..7 = do..si, 0 = silent (speaker held 0, divider cleared)
//   pitch_i    : 01 low (half-period x2), 10 high (/2), 00/11 middle
//   speaker_o  : registered square wave, toggles every half-period cycles
module tone_gen
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] note_i,
    input  logic [1:0] pitch_i,
    output logic       speaker_o
);

    logic [31:0] base_s;
    logic [31:0] half_s;
    logic [31:0] cnt_d, cnt_q;
    logic        spk_d, spk_q;

    // Half-period lookup: divisions are on constants only.
    always_comb begin
        base_s = 32'd0;
        case (note_i)
            3'd1:    base_s = 32'(CLK_HZ / (2 * NOTE_HZ[1]));
            3'd2:    base_s = 32'(CLK_HZ / (2 * NOTE_HZ[2]));
            3'd3:    base_s = 32'(CLK_HZ / (2 * NOTE_HZ[3]));
            3'd4:    base_s = 32'(CLK_HZ / (2 * NOTE_HZ[4]));
            3'd5:    base_s = 32'(CLK_HZ / (2 * NOTE_HZ[5]));
            3'd6:    base_s = 32'(CLK_HZ / (2 * NOTE_HZ[6]));
            3'd7:    base_s = 32'(CLK_HZ / (2 * NOTE_HZ[7]));
            default: base_s = 32'd0;
        endcase
        case (norm_pitch(pitch_i))
            PITCH_LOW:  half_s = base_s << 1;
            PITCH_HIGH: half_s = base_s >> 1;
            default:    half_s = base_s;
        endcase
    end

    // Divider: count to half-period-1, then toggle.
    always_comb begin
        cnt_d = cnt_q;
        spk_d = spk_q;
        if ((note_i == 3'd0) || (half_s == 32'd0)) begin
            cnt_d = 32'd0;
            spk_d = 1'b0;
        end else if (cnt_q >= (half_s - 32'd1)) begin
            cnt_d = 32'd0;
            spk_d = ~spk_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Divider and speaker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
            spk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            spk_q <= spk_d;
        end
    end

    assign speaker_o = spk_q;

endmodule

// File: rtl/piano_core.sv
// piano_core: sound-and-light engine for auto, free and learning modes.
//   clk, rst_n : clock, async active-low reset
//   bus        : piano_if.slave (mode, song_num, pause, key, pitch in;
//                speaker, led, finished, score out)
// Parameters: CLK_HZ (tone dividers), BEAT_CYCLES (cycles per note slot).
// Build option: AUTO_LOOP_EN -- when defined, auto mode wraps to slot 0 at
// the end marker; otherwise it stops silent and dark until mode/song change.
module piano_core
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned BEAT_CYCLES = 25_000_000
) (
    input  logic     clk,
    input  logic     rst_n,
    piano_if.slave   bus
);

    logic [2:0]  mode_q;
    logic [1:0]  song_q;
    logic [6:0]  key_q;
    logic [4:0]  idx_d, idx_q;
    logic [31:0] beat_d, beat_q;
    logic [3:0]  waited_d, waited_q;
    logic [32:0] score_d, score_q;
    logic        finished_d, finished_q;
    logic        done_d, done_q;
    logic [7:0]  led_d, led_q;

    slot_t       slot_s;
    logic        clear_s;
    logic        key_rise_s;
    logic        beat_tick_s;
    logic        correct_s;
    logic [3:0]  points_s;
    logic [2:0]  press_note_s;
    logic [2:0]  tone_note_s;
    logic [1:0]  tone_pitch_s;
    logic        speaker_s;

    // Event decode shared by all modes.
    always_comb begin
        slot_s       = song_slot(bus.song_num, idx_q);
        clear_s      = (bus.mode != mode_q) || (bus.song_num != song_q);
        key_rise_s   = (key_q == 7'd0) && (bus.key != 7'd0);
        beat_tick_s  = (beat_q >= 32'(BEAT_CYCLES - 1));
        press_note_s = lowest_key(bus.key);
        correct_s    = ({1'b0, bus.key} == note_led(slot_s.note)) &&
                       (norm_pitch(bus.pitch) == norm_pitch(slot_s.pitch));
        // Late presses earn nothing; waited saturates at 8.
        points_s     = (waited_q >= 4'd8) ? 4'd0 : (4'd8 - waited_q);
    end

    // Next-state and output selection per mode.
    always_comb begin
        idx_d        = idx_q;
        beat_d       = beat_q;
        waited_d     = waited_q;
        score_d      = score_q;
        finished_d   = finished_q;
        done_d       = done_q;
        led_d        = 8'h00;
        tone_note_s  = 3'd0;
        tone_pitch_s = PITCH_MID;
        if (clear_s) begin
            idx_d      = 5'd0;
            beat_d     = 32'd0;
            waited_d   = 4'd0;
            score_d    = 33'd0;
            finished_d = 1'b0;
            done_d     = 1'b0;
        end else begin
            case (bus.mode)
                MODE_AUTO: begin
                    if (bus.pause) begin
                        led_d = 8'h80;
                    end else if (done_q) begin
                        led_d = 8'h00;
                    end else if (slot_s == END_SLOT) begin
`ifdef AUTO_LOOP_EN
                        idx_d  = 5'd0;
                        beat_d = 32'd0;
`else
                        done_d = 1'b1;
`endif
                    end else begin
                        led_d        = note_led(slot_s.note);
                        tone_note_s  = slot_s.note;
                        tone_pitch_s = slot_s.pitch;
                        if (beat_tick_s) begin
                            beat_d = 32'd0;
                            idx_d  = idx_q + 5'd1;
                        end else begin
                            beat_d = beat_q + 32'd1;
                        end
                    end
                end
                MODE_FREE: begin
                    tone_note_s  = press_note_s;
                    tone_pitch_s = bus.pitch;
                end
                MODE_LEARN: begin
                    tone_note_s  = press_note_s;
                    tone_pitch_s = bus.pitch;
                    if (finished_q) begin
                        led_d = 8'h00;
                    end else if (slot_s == END_SLOT) begin
                        finished_d = 1'b1;
                    end else if (slot_s.note == 3'd0) begin
                        // Rest: move on after one beat, no scoring.
                        if (beat_tick_s) begin
                            beat_d   = 32'd0;
                            idx_d    = idx_q + 5'd1;
                            waited_d = 4'd0;
                        end else begin
                            beat_d = beat_q + 32'd1;
                        end
                    end else begin
                        led_d = note_led(slot_s.note);
                        // A press wins over a same-cycle beat tick, so it
                        // is scored with the pre-tick waited count.
                        if (key_rise_s && correct_s) begin
                            score_d  = score_q + {29'd0, points_s};
                            idx_d    = idx_q + 5'd1;
                            beat_d   = 32'd0;
                            waited_d = 4'd0;
                        end else if (beat_tick_s) begin
                            beat_d   = 32'd0;
                            waited_d = (waited_q >= 4'd8) ? 4'd8 : (waited_q + 4'd1);
                        end else begin
                            beat_d = beat_q + 32'd1;
                        end
                    end
                end
                default: begin
                    idx_d      = 5'd0;
                    beat_d     = 32'd0;
                    waited_d   = 4'd0;
                    score_d    = 33'd0;
                    finished_d = 1'b0;
                    done_d     = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 3'd0;
            song_q     <= 2'd0;
            key_q      <= 7'd0;
            idx_q      <= 5'd0;
            beat_q     <= 32'd0;
            waited_q   <= 4'd0;
            score_q    <= 33'd0;
            finished_q <= 1'b0;
            done_q     <= 1'b0;
            led_q      <= 8'h00;
        end else begin
            mode_q     <= bus.mode;
            song_q     <= bus.song_num;
            key_q      <= bus.key;
            idx_q      <= idx_d;
            beat_q     <= beat_d;
            waited_q   <= waited_d;
            score_q    <= score_d;
            finished_q <= finished_d;
            done_q     <= done_d;
            led_q      <= led_d;
        end
    end

    tone_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tone_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .note_i    (tone_note_s),
        .pitch_i   (tone_pitch_s),
        .speaker_o (speaker_s)
    );

    assign bus.speaker  = speaker_s;
    assign bus.led      = led_q;
    assign bus.finished = finished_q;
    assign bus.score    = score_q;

endmodule

// File: tb/tb_piano_core.sv
// tb_piano_core: self-checking bench for piano_core with CLK_HZ=100_000,
// BEAT_CYCLES=1000. Expected values are queued when stimulus is applied and
// popped when the corresponding output is observed.
module tb_piano_core;

    logic clk;
    logic rst_n;

    piano_if bus();

    piano_core #(
        .CLK_HZ      (100_000),
        .BEAT_CYCLES (1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] exp;
    } sb_t;

    typedef struct {
        logic [6:0]  key;
        logic [1:0]  pitch;
        int unsigned half;
        logic [7:0]  led;
    } free_vec_t;

    typedef struct {
        logic [6:0] key;
        logic [1:0] pitch;
    } press_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string n, input logic [63:0] e);
        sb_q.push_back('{n, e});
    endtask

    task automatic observe(input logic [63:0] act);
        sb_t s;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got %0d with no expectation queued", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                errors++;
                $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                         s.name, act, act, s.exp, s.exp);
            end
        end
    endtask

    // Skips two toggles to let the divider settle, returns the third interval;
    // 0 if the speaker stops toggling within the bound.
    task automatic measure_half(output int half);
        logic prev;
        int   cnt;
        int   toggles;
        prev    = bus.speaker;
        cnt     = 0;
        toggles = 0;
        half    = 0;
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            cnt++;
            if (bus.speaker !== prev) begin
                prev = bus.speaker;
                toggles++;
                if (toggles == 3) begin
                    half = cnt;
                    break;
                end
                cnt = 0;
            end
        end
    endtask

    task automatic count_toggles(input int n, output int t);
        logic prev;
        prev = bus.speaker;
        t    = 0;
        for (int c = 0; c < n; c++) begin
            tick(1);
            if (bus.speaker !== prev) begin
                t++;
                prev = bus.speaker;
            end
        end
    endtask

    task automatic press(input logic [6:0] k, input logic [1:0] p);
        bus.key   = k;
        bus.pitch = p;
        tick(2);
        bus.key   = 7'd0;
        tick(2);
    endtask

    initial begin
        free_vec_t free_vecs [8];
        press_t    song0 [7];
        logic [7:0] auto_leds [7];
        int half;
        int tg;

        free_vecs = '{
            '{7'b0100000, 2'b00, 113, 8'h00},
            '{7'b0100000, 2'b01, 226, 8'h00},
            '{7'b0100000, 2'b10,  56, 8'h00},
            '{7'b0100000, 2'b11, 113, 8'h00},
            '{7'b0000001, 2'b00, 190, 8'h00},
            '{7'b1000100, 2'b00, 151, 8'h00},
            '{7'b1000000, 2'b10,  50, 8'h00},
            '{7'b0000000, 2'b00,   0, 8'h00}
        };
        song0 = '{
            '{7'b0000001, 2'b00}, '{7'b0000001, 2'b00}, '{7'b0010000, 2'b11},
            '{7'b0010000, 2'b00}, '{7'b0100000, 2'b00}, '{7'b0100000, 2'b00},
            '{7'b0010000, 2'b00}
        };
        auto_leds = '{8'h01, 8'h01, 8'h10, 8'h10, 8'h20, 8'h20, 8'h10};

        // Reset state
        rst_n        = 1'b0;
        bus.mode     = 3'b000;
        bus.song_num = 2'd0;
        bus.pause    = 1'b0;
        bus.key      = 7'd0;
        bus.pitch    = 2'b00;
        tick(3);
        expect_val("reset_speaker", 64'd0);  observe({63'd0, bus.speaker});
        expect_val("reset_led", 64'd0);      observe({56'd0, bus.led});
        expect_val("reset_finished", 64'd0); observe({63'd0, bus.finished});
        expect_val("reset_score", 64'd0);    observe({31'd0, bus.score});
        rst_n = 1'b1;
        tick(2);

        // Free mode: tone table and pitch scaling
        bus.mode = 3'b001;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            bus.key   = free_vecs[i].key;
            bus.pitch = free_vecs[i].pitch;
            expect_val($sformatf("free_led[%0d]", i), {56'd0, free_vecs[i].led});
            expect_val($sformatf("free_half[%0d]", i), 64'(free_vecs[i].half));
            tick(2);
            observe({56'd0, bus.led});
            measure_half(half);
            observe(64'(half));
        end
        expect_val("free_nokey_speaker", 64'd0);
        observe({63'd0, bus.speaker});

        // Auto mode: song 0 LED sequence
        bus.mode = 3'b011;
        for (int i = 0; i < 7; i++) expect_val($sformatf("auto_led[%0d]", i), {56'd0, auto_leds[i]});
        tick(500);
        for (int i = 0; i < 7; i++) begin
            observe({56'd0, bus.led});
            tick(1000);
        end

        // Auto mode: pause freezes slot, silences speaker
        bus.mode = 3'b000;
        tick(2);
        bus.mode = 3'b011;
        tick(2500);
        bus.pause = 1'b1;
        expect_val("pause_led", 64'h80);
        expect_val("pause_toggles", 64'd0);
        expect_val("pause_speaker", 64'd0);
        tick(3);
        observe({56'd0, bus.led});
        count_toggles(3000, tg);
        observe(64'(tg));
        observe({63'd0, bus.speaker});
        bus.pause = 1'b0;
        expect_val("resume_same_slot", 64'h10);
        expect_val("resume_later_slot", 64'h20);
        expect_val("auto_la_half", 64'd113);
        tick(200);
        observe({56'd0, bus.led});
        tick(1600);
        observe({56'd0, bus.led});
        measure_half(half);
        observe(64'(half));

        // Auto mode: end of song
        tick(4000);
`ifdef AUTO_LOOP_EN
        expect_val("auto_wrap_led", 64'h01);
        observe({56'd0, bus.led});
`else
        expect_val("auto_end_led", 64'h00);
        expect_val("auto_end_toggles", 64'd0);
        observe({56'd0, bus.led});
        count_toggles(500, tg);
        observe(64'(tg));
`endif

        // Reset mid-song
        bus.mode = 3'b000;
        tick(2);
        bus.mode = 3'b011;
        tick(2500);
        rst_n = 1'b0;
        #2;
        expect_val("midreset_led", 64'd0);
        observe({56'd0, bus.led});
        tick(2);
        rst_n = 1'b1;
        expect_val("restart_slot0_led", 64'h01);
        tick(500);
        observe({56'd0, bus.led});

        // Learning mode: wrong key, then correct key 1.5 beats in
        bus.mode  = 3'b111;
        bus.key   = 7'd0;
        bus.pitch = 2'b00;
        tick(3);
        expect_val("learn_led0", 64'h01);
        observe({56'd0, bus.led});
        press(7'b0000010, 2'b00);
        expect_val("learn_wrong_score", 64'd0);
        expect_val("learn_wrong_led", 64'h01);
        observe({31'd0, bus.score});
        observe({56'd0, bus.led});
        tick(1489);
        press(7'b0000001, 2'b00);
        expect_val("learn_late_score", 64'd7);
        observe({31'd0, bus.score});
        for (int i = 1; i < 7; i++) press(song0[i].key, song0[i].pitch);
        expect_val("learn_run1_score", 64'd55);
        observe({31'd0, bus.score});
        tick(1100);
        expect_val("learn_run1_finished", 64'd1);
        expect_val("learn_run1_led", 64'd0);
        observe({63'd0, bus.finished});
        observe({56'd0, bus.led});

        // Song change clears
        bus.song_num = 2'd1;
        tick(3);
        expect_val("song_change_finished", 64'd0);
        expect_val("song_change_score", 64'd0);
        expect_val("song1_led0", 64'h04);
        observe({63'd0, bus.finished});
        observe({31'd0, bus.score});
        observe({56'd0, bus.led});

        // Learning mode: pitch mismatch, then all immediate
        bus.song_num = 2'd0;
        tick(3);
        press(7'b0000001, 2'b10);
        expect_val("learn_pitch_mismatch", 64'd0);
        observe({31'd0, bus.score});
        for (int i = 0; i < 7; i++) press(song0[i].key, song0[i].pitch);
        tick(1100);
        expect_val("learn_full_finished", 64'd1);
        expect_val("learn_full_score", 64'd56);
        observe({63'd0, bus.finished});
        observe({31'd0, bus.score});
        press(7'b0000001, 2'b00);
        expect_val("learn_frozen_score", 64'd56);
        observe({31'd0, bus.score});

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expectations never observed", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
